// File: rtl/spi_slave_if_if.sv
// spi_slave_if_if: signal bundle between the SPI front end and its environment.
//   slave modport  : the SPI front end (spi_slave_if)
//   master modport : SPI master + RAM side (drives ss_n/mosi and tx_*)
// Signals:
//   ss_n     slave select, active-low
//   mosi     serial data in, MSB first
//   miso     serial data out, MSB first
//   rx_data  CMD_W command word to RAM ([9:8] opcode, [7:0] addr/data)
//   rx_valid one-cycle strobe qualifying rx_data
//   tx_data  DATA_W read data from RAM
//   tx_valid tx_data valid
interface spi_slave_if_if #(
  parameter int CMD_W  = 10,
  parameter int DATA_W = 8
);
  logic              ss_n;
  logic              mosi;
  logic              miso;
  logic [CMD_W-1:0]  rx_data;
  logic              rx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;

  modport slave (
    input  ss_n, mosi, tx_data, tx_valid,
    output miso, rx_data, rx_valid
  );

  modport master (
    output ss_n, mosi, tx_data, tx_valid,
    input  miso, rx_data, rx_valid
  );
endinterface

// File: rtl/spi_slave_if.sv
// spi_slave_if: SPI slave front end for the single-port RAM command path.
// Deserialises MOSI frames into CMD_W command words and, for a read-data
// command, returns the RAM's DATA_W response on MISO. SCK is clk.
// Ports:
//   clk    system/SPI clock, rising edge
//   rst_n  synchronous active-low reset
//   bus    spi_slave_if_if.slave (ss_n, mosi, miso, rx_data, rx_valid,
//          tx_data, tx_valid)
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for ss_n low; miso 0, counter 0
// CHK_CMD   | sampling select bit on mosi
// WRITE     | receiving write word, then ignoring mosi until ss_n rises
// READ_ADD  | receiving read-address word; completion sets rd_addr_seen
// READ_DATA | receiving read-data word, then waiting for tx_valid and
//           | shifting the captured byte out on miso
module spi_slave_if #(
  parameter int CMD_W  = 10,
  parameter int DATA_W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  spi_slave_if_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } state_t;

  localparam logic [3:0] WORD_BITS = 4'(CMD_W);
  localparam logic [3:0] LAST_BIT  = 4'(CMD_W - 1);

  state_t            state_q, state_d;
  logic [3:0]        bit_cnt;
  logic [CMD_W-1:0]  rx_sr;
  logic [DATA_W-1:0] tx_sr;
  logic              rd_addr_seen;
  logic              tx_loaded;
  logic              miso_q;
  logic [CMD_W-1:0]  rx_data_q;
  logic              rx_valid_q;

  logic rx_phase;
  logic word_done;
  logic tx_capture;

  assign bus.miso     = miso_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;

  always_comb begin
    state_d    = state_q;
    rx_phase   = 1'b0;
    word_done  = 1'b0;
    tx_capture = 1'b0;
    // ss_n high wins over everything else sampled on the same edge
    if (bus.ss_n) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = CHK_CMD;
        CHK_CMD: begin
          if (!bus.mosi)        state_d = WRITE;
          else if (rd_addr_seen) state_d = READ_DATA;
          else                   state_d = READ_ADD;
        end
        WRITE, READ_ADD, READ_DATA: begin
          rx_phase   = (bit_cnt < WORD_BITS);
          word_done  = rx_phase && (bit_cnt == LAST_BIT);
          tx_capture = (state_q == READ_DATA) && !rx_phase && !tx_loaded
                       && bus.tx_valid;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      bit_cnt      <= '0;
      rx_sr        <= '0;
      tx_sr        <= '0;
      rd_addr_seen <= 1'b0;
      tx_loaded    <= 1'b0;
      miso_q       <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_valid_q <= word_done;

      if (word_done) begin
        rx_data_q <= {rx_sr[CMD_W-2:0], bus.mosi};
        if (state_q == READ_ADD)  rd_addr_seen <= 1'b1;
        if (state_q == READ_DATA) rd_addr_seen <= 1'b0;
      end

      if (state_d == IDLE) begin
        bit_cnt   <= '0;
        tx_loaded <= 1'b0;
        tx_sr     <= '0;
        miso_q    <= 1'b0;
      end else begin
        if (rx_phase) begin
          rx_sr   <= {rx_sr[CMD_W-2:0], bus.mosi};
          bit_cnt <= bit_cnt + 4'd1;
        end
        // Zero-fill on shift so miso falls to 0 by itself after the last bit.
        if (tx_capture) begin
          tx_loaded <= 1'b1;
          miso_q    <= bus.tx_data[DATA_W-1];
          tx_sr     <= {bus.tx_data[DATA_W-2:0], 1'b0};
        end else if (tx_loaded) begin
          miso_q <= tx_sr[DATA_W-1];
          tx_sr  <= {tx_sr[DATA_W-2:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_if.sv
// tb_spi_slave_if: directed + randomized frames against a frame-level model.
// The model tracks only the last completed word and whether a read address
// has been seen; per-frame expectations (rx_valid cycle, miso bit train)
// are derived from the frame's edge numbering.
module tb_spi_slave_if;
  localparam int CMD_W  = 10;
  localparam int DATA_W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_slave_if_if #(.CMD_W(CMD_W), .DATA_W(DATA_W)) bus ();

  spi_slave_if #(.CMD_W(CMD_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [CMD_W-1:0] exp_rx   = '0;
  logic             exp_seen = 1'b0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic rbit();
    return 1'($urandom);
  endfunction

  function automatic logic [7:0] rbyte();
    return 8'($urandom);
  endfunction

  // Called at a negedge: drive inputs for the next rising edge, then check
  // the outputs at the following negedge.
  task automatic tick(input logic ss, input logic mo, input logic tv,
                      input logic [7:0] td, input logic exp_v,
                      input logic exp_m, input string tag);
    bus.ss_n     = ss;
    bus.mosi     = mo;
    bus.tx_valid = tv;
    bus.tx_data  = td;
    @(posedge clk);
    @(negedge clk);
    check({tag, "/rx_valid"}, 32'(bus.rx_valid), 32'(exp_v));
    check({tag, "/miso"},     32'(bus.miso),     32'(exp_m));
    check({tag, "/rx_data"},  32'(bus.rx_data),  32'(exp_rx));
  endtask

  // nbits < 10 aborts after that many data bits; rst_at >= 1 asserts reset
  // on the edge that would output miso bit index rst_at of a read-data frame.
  task automatic frame(input logic sel, input logic [9:0] word,
                       input int nbits, input int tx_delay,
                       input logic [7:0] tx_byte, input int rst_at,
                       input string tag);
    logic is_rd;
    logic exp_m;
    is_rd = sel && exp_seen;
    tick(1'b0, rbit(), rbit(), 8'hFF, 1'b0, 1'b0, {tag, "/E0"});
    tick(1'b0, sel,    rbit(), 8'hFF, 1'b0, 1'b0, {tag, "/sel"});
    for (int i = 0; i < nbits; i++) begin
      if (i == CMD_W - 1) exp_rx = word;
      tick(1'b0, word[9-i], rbit(), 8'hFF, (i == CMD_W - 1), 1'b0,
           {tag, "/bit"});
    end
    if (nbits < CMD_W) begin
      tick(1'b1, rbit(), rbit(), 8'hFF, 1'b0, 1'b0, {tag, "/abort"});
      return;
    end
    if (sel) exp_seen = !is_rd;
    if (is_rd) begin
      for (int d = 0; d < tx_delay; d++)
        tick(1'b0, rbit(), 1'b0, rbyte(), 1'b0, 1'b0, {tag, "/wait"});
      tick(1'b0, rbit(), 1'b1, tx_byte, 1'b0, tx_byte[7], {tag, "/cap"});
      for (int j = 1; j < 10; j++) begin
        if (j == rst_at) begin
          rst_n    = 1'b0;
          exp_rx   = '0;
          exp_seen = 1'b0;
          tick(1'b0, rbit(), 1'b1, 8'hFF, 1'b0, 1'b0, {tag, "/rst"});
          rst_n = 1'b1;
          tick(1'b1, rbit(), rbit(), 8'hFF, 1'b0, 1'b0, {tag, "/rst_gap"});
          return;
        end
        exp_m = (j < DATA_W) ? tx_byte[7-j] : 1'b0;
        tick(1'b0, rbit(), rbit(), rbyte(), 1'b0, exp_m, {tag, "/shift"});
      end
    end else begin
      for (int k = 0; k < 4; k++)
        tick(1'b0, rbit(), 1'b1, 8'hFF, 1'b0, 1'b0, {tag, "/post"});
    end
    tick(1'b1, rbit(), rbit(), rbyte(), 1'b0, 1'b0, {tag, "/gap"});
  endtask

  initial begin
    bus.ss_n     = 1'b1;
    bus.mosi     = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;
    rst_n        = 1'b0;
    @(negedge clk);
    tick(1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, "reset");
    tick(1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, "reset");
    rst_n = 1'b1;
    tick(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, "idle");

    frame(1'b0, 10'h0A5, 10, 0, 8'h00, -1, "wr_addr");
    frame(1'b0, 10'h13C, 10, 0, 8'h00, -1, "wr_data");
    frame(1'b1, 10'h203, 10, 0, 8'h00, -1, "rd_addr");
    frame(1'b1, 10'h300, 10, 1, 8'hC3, -1, "rd_data");
    frame(1'b0, 10'h3FF,  5, 0, 8'h00, -1, "abort5");
    frame(1'b0, 10'h001, 10, 0, 8'h00, -1, "after_abort");
    frame(1'b0, 10'h2AA,  9, 0, 8'h00, -1, "abort9");
    frame(1'b1, 10'h155,  0, 0, 8'h00, -1, "abort0");
    frame(1'b1, 10'h2AA, 10, 0, 8'h00, -1, "rd_addr2");
    frame(1'b1, 10'h355,  3, 0, 8'h00, -1, "rd_abort");
    frame(1'b1, 10'h3A5, 10, 0, 8'h81, -1, "rd_data_d0");
    frame(1'b1, 10'h211, 10, 0, 8'h00, -1, "rd_addr3");
    frame(1'b1, 10'h3C0, 10, 1, 8'hA5,  4, "rst_mid");
    frame(1'b1, 10'h2F0, 10, 0, 8'h00, -1, "post_rst_rd_addr");
    frame(1'b1, 10'h30F, 10, 2, 8'h5A, -1, "rd_data_d2");

    for (int n = 0; n < 60; n++) begin
      frame(rbit(), 10'($urandom),
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : 10,
            int'($urandom_range(0, 3)), rbyte(),
            ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 8)) : -1,
            "rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
